clint_multi_hart: RTL
=====================

Name: clint_multi_hart

Overview:
- Parametrised core-local interruptor serving HART_NUM harts.
- Holds one shared 64-bit mtime with a programmable-rate prescaler, plus per-hart msip and 64-bit mtimecmp.
- Drives per-hart software and timer interrupt request lines into the interrupt interface.
- Sits on the system bus as a word-accessed slave with registered read data.

Parameters:
- HART_NUM, 2, number of harts (1..16); sets msip/mtimecmp instance count and interrupt vector widths
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width; each 64-bit register is accessed as lo/hi halves
- SIZE_WIDTH, 2, bus access size field width; 'b10 = 32-bit word
- TICK_DIV, 1, clk cycles per mtime increment (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- bus_read_addr  in  ADDR_WIDTH  read address, offset from block base
- bus_write_addr  in  ADDR_WIDTH  write address, offset from block base
- bus_read_size  in  SIZE_WIDTH  read access size
- bus_write_size  in  SIZE_WIDTH  write access size
- bus_write_data  in  DATA_WIDTH  write data
- bus_rd  in  1  read strobe
- bus_wr  in  1  write strobe
- clint_bus_data  out  DATA_WIDTH  registered read data
- int_software_req  out  HART_NUM  per-hart software interrupt request
- int_timer_req  out  HART_NUM  per-hart timer interrupt request

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values:
  - msip[h] = 0; mtimecmp[h] = all ones (no spurious timer interrupt); mtime = 0; prescaler count = 0
  - clint_bus_data = 0; int_software_req = 0; int_timer_req = 0
- Address map (word offsets):
  - msip[h] at 0x0000 + 4h
  - mtimecmp[h] lo at 0x4000 + 8h, hi at 0x4004 + 8h
  - mtime lo at 0xBFF8, hi at 0xBFFC
  - Addresses for h >= HART_NUM, and all other addresses, are unmapped.
- Writes:
  - Accepted only when bus_wr=1 and bus_write_size=='b10; any other size is ignored with no state change.
  - msip write stores bit 0 only; other data bits are dropped.
  - Half-register write updates only the addressed 32 bits; the other half is unchanged.
  - Unmapped writes are ignored.
- Prescaler:
  - Count runs 0..TICK_DIV-1; on count==TICK_DIV-1, mtime increments by 1 and count returns to 0.
  - With TICK_DIV=1, mtime increments every cycle.
  - mtime wraps from 2^64-1 to 0 with no flag.
- mtime write:
  - Written half takes the write data; no increment occurs that cycle; prescaler count is cleared to 0.
  - The write wins over a coincident tick.
- Reads:
  - bus_rd=1 → clint_bus_data is loaded on the next clk edge with the addressed 32-bit value (1-cycle latency).
  - msip reads zero-extended.
  - Unmapped or non-word reads return 0.
  - bus_rd=0 → clint_bus_data holds its previous value.
  - Read and write in the same cycle to the same address → read returns the pre-write value.
- Interrupts:
  - int_software_req[h] = msip[h], combinational from the register.
  - int_timer_req[h] is registered: each cycle it loads (mtime >= mtimecmp[h]) using current register values, an unsigned 64-bit compare.
  - Interrupt lines are level; int_timer_req[h] deasserts one cycle after mtimecmp[h] is raised above mtime.
- Reset mid-operation: all state returns to reset values on the same edge; in-flight read data is discarded (reads 0).

Test Plan:
- Reset, then read 0x4000 and 0x4004 for hart 0 → both return 0xFFFFFFFF one cycle after bus_rd; int_timer_req=0.
- TICK_DIV=1: write mtimecmp[1] lo=0x20, hi=0 → int_timer_req[1] rises when mtime reaches 0x20 (registered, +1 cycle); int_timer_req[0] stays 0.
- TICK_DIV=4: read mtime lo at two points 40 cycles apart → difference 10; write mtime lo=0xFFFFFFFF, hi=0 → after 4 more cycles hi=1, lo=0 (carry across halves).
- Write 0xFFFFFFFF to msip[1] (0x0004) → int_software_req=2'b10, read returns 0x1; write with size 'b01 → no change.
- Same-cycle read and write of 0x4008 (old value A, new value B) → read data = A; next read returns B. Read of 0x4010 with HART_NUM=2 → 0.
- Assert rst while int_timer_req=2'b11 and prescaler mid-count → next cycle outputs are 0, mtime=0, mtimecmp all ones.

Source files
------------

// File: rtl/clint_multi_hart.sv
`default_nettype none
// ============================================================================
// Module   : clint_multi_hart
// Purpose  : Core-local interruptor with one shared prescaled 64-bit mtime,
//            per-hart msip and 64-bit mtimecmp, word-accessed bus slave.
// Revision : 1.0
// ============================================================================
module clint_multi_hart #(
   parameter int HART_NUM   = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SIZE_WIDTH = 2,
   parameter int TICK_DIV   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] bus_read_addr,
   input  logic [ADDR_WIDTH-1:0] bus_write_addr,
   input  logic [SIZE_WIDTH-1:0] bus_read_size,
   input  logic [SIZE_WIDTH-1:0] bus_write_size,
   input  logic [DATA_WIDTH-1:0] bus_write_data,
   input  logic                  bus_rd,
   input  logic                  bus_wr,
   output logic [DATA_WIDTH-1:0] clint_bus_data,
   output logic [HART_NUM-1:0]   int_software_req,
   output logic [HART_NUM-1:0]   int_timer_req
);

   localparam int                    C_CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [C_CNT_W-1:0]    C_CNT_MAX   = C_CNT_W'(TICK_DIV - 1);
   localparam logic [SIZE_WIDTH-1:0] C_SIZE_WORD = SIZE_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] C_CMP_BASE  = ADDR_WIDTH'(32'h4000);
   localparam logic [ADDR_WIDTH-1:0] C_MTIME_LO  = ADDR_WIDTH'(32'hBFF8);
   localparam logic [ADDR_WIDTH-1:0] C_MTIME_HI  = ADDR_WIDTH'(32'hBFFC);

   logic [63:0]          r_mtime;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [HART_NUM-1:0]  r_msip;
   logic [63:0]          r_mtimecmp [HART_NUM];
   logic [HART_NUM-1:0]  r_timer_req;

   logic                 w_wr_en;
   logic                 w_mtime_lo_we;
   logic                 w_mtime_hi_we;
   logic                 w_tick;
   logic [31:0]          w_wdata;
   logic [31:0]          w_rd_word;

   assign w_wr_en       = bus_wr && (bus_write_size == C_SIZE_WORD);
   assign w_mtime_lo_we = w_wr_en && (bus_write_addr == C_MTIME_LO);
   assign w_mtime_hi_we = w_wr_en && (bus_write_addr == C_MTIME_HI);
   assign w_tick        = (r_cnt == C_CNT_MAX);
   assign w_wdata       = 32'(bus_write_data);

   // A software write to either mtime half restarts the prescaler and
   // suppresses that cycle's increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mtime <= '0;
         r_cnt   <= '0;
      end else if (w_mtime_lo_we || w_mtime_hi_we) begin
         if (w_mtime_lo_we) r_mtime[31:0]  <= w_wdata;
         if (w_mtime_hi_we) r_mtime[63:32] <= w_wdata;
         r_cnt <= '0;
      end else if (w_tick) begin
         r_mtime <= r_mtime + 64'd1;
         r_cnt   <= '0;
      end else begin
         r_cnt <= r_cnt + C_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      for (int h = 0; h < HART_NUM; h++) begin
         if (rst) begin
            r_msip[h]      <= 1'b0;
            r_mtimecmp[h]  <= '1;
            r_timer_req[h] <= 1'b0;
         end else begin
            r_timer_req[h] <= (r_mtime >= r_mtimecmp[h]);
            if (w_wr_en && (bus_write_addr == ADDR_WIDTH'(4 * h)))
               r_msip[h] <= w_wdata[0];
            if (w_wr_en && (bus_write_addr == C_CMP_BASE + ADDR_WIDTH'(8 * h)))
               r_mtimecmp[h][31:0] <= w_wdata;
            if (w_wr_en && (bus_write_addr == C_CMP_BASE + ADDR_WIDTH'(8 * h + 4)))
               r_mtimecmp[h][63:32] <= w_wdata;
         end
      end
   end

   always_comb begin
      w_rd_word = '0;
      if (bus_read_size == C_SIZE_WORD) begin
         if (bus_read_addr == C_MTIME_LO) w_rd_word = r_mtime[31:0];
         if (bus_read_addr == C_MTIME_HI) w_rd_word = r_mtime[63:32];
         for (int h = 0; h < HART_NUM; h++) begin
            if (bus_read_addr == ADDR_WIDTH'(4 * h))
               w_rd_word = {31'd0, r_msip[h]};
            if (bus_read_addr == C_CMP_BASE + ADDR_WIDTH'(8 * h))
               w_rd_word = r_mtimecmp[h][31:0];
            if (bus_read_addr == C_CMP_BASE + ADDR_WIDTH'(8 * h + 4))
               w_rd_word = r_mtimecmp[h][63:32];
         end
      end
   end

   // Read data is sampled from pre-write register state, so a coincident
   // write to the same address is not visible until the next read.
   always_ff @(posedge clk) begin
      if (rst)
         clint_bus_data <= '0;
      else if (bus_rd)
         clint_bus_data <= DATA_WIDTH'(w_rd_word);
   end

   assign int_software_req = r_msip;
   assign int_timer_req    = r_timer_req;

endmodule
`default_nettype wire
